// File: rtl/command_fetch_pkg.sv
// Shared definitions for the command fetch unit and its consumers.
// Contents:
//   - command word field positions (opcode / operand1 / operand2)
//   - opcode encodings
//   - operand address-flag bit position
//   - fetch FSM state encoding
//   - is_halt() helper that decodes the HALT opcode from a command word
package command_fetch_pkg;

  localparam int OPCODE_MSB = 23;
  localparam int OPCODE_LSB = 18;
  localparam int OPND1_MSB  = 17;
  localparam int OPND1_LSB  = 9;
  localparam int OPND2_MSB  = 8;
  localparam int OPND2_LSB  = 0;

  // Top bit of each 9-bit operand marks it as a memory address rather than a literal.
  localparam int OPND_ADDR_FLAG_BIT = 8;

  typedef enum logic [5:0] {
    OP_HALT = 6'd0,
    OP_ADD  = 6'd1,
    OP_SUB  = 6'd2,
    OP_INV  = 6'd3,
    OP_MOV  = 6'd4,
    OP_JFE  = 6'd5,
    OP_JFL  = 6'd6,
    OP_JFG  = 6'd7
  } opcode_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  function automatic logic is_halt(input logic [23:0] cmd);
    return cmd[OPCODE_MSB:OPCODE_LSB] == OP_HALT;
  endfunction

endpackage

// File: rtl/command_fetch_if.sv
// Bus bundle between the command fetch unit and its environment.
// Ports carried:
//   memRdEn / memAddr / memData             program ROM read port
//   commandOut / commandValid / commandReady head command handshake
//   instructionPointer                      ROM address of commandOut
//   jumpValid / jumpTarget                  redirect request from downstream
//   halted                                  HALT seen, fetching stopped
// Modports:
//   master - the fetch unit (drives ROM request and command outputs)
//   slave  - ROM + consumer side
interface command_fetch_if #(
  parameter int ADDR_W = 8,
  parameter int CMD_W  = 24
);
  logic              memRdEn;
  logic [ADDR_W-1:0] memAddr;
  logic [CMD_W-1:0]  memData;
  logic [CMD_W-1:0]  commandOut;
  logic              commandValid;
  logic              commandReady;
  logic [ADDR_W-1:0] instructionPointer;
  logic              jumpValid;
  logic [ADDR_W-1:0] jumpTarget;
  logic              halted;

  modport master (
    output memRdEn, memAddr, commandOut, commandValid, instructionPointer, halted,
    input  memData, commandReady, jumpValid, jumpTarget
  );

  modport slave (
    input  memRdEn, memAddr, commandOut, commandValid, instructionPointer, halted,
    output memData, commandReady, jumpValid, jumpTarget
  );
endinterface

// File: rtl/command_fetch_cmd_fifo.sv
// cmd_fifo: 2-deep synchronous FIFO holding {address, command} entries.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   push_i         write wdata_i this cycle
//   pop_i          drop the head entry this cycle
//   flush_i        empty the FIFO (overrides push and pop)
//   wdata_i        entry to write
//   rdata_o        head entry (meaningful while count_o != 0)
//   count_o        number of stored entries, 0..2
// Only pointers and count are reset; storage content is don't-care while empty.
module cmd_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [1:0]       count_o
);
  logic [WIDTH-1:0] mem_q [2];
  logic             wptr_q;
  logic             rptr_q;
  logic [1:0]       count_q;
  logic             full;

  assign full = (count_q == 2'd2);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= 2'd0;
    end else if (flush_i) begin
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push_i) wptr_q <= ~wptr_q;
      if (pop_i)  rptr_q <= ~rptr_q;
      count_q <= count_q + 2'(push_i) - 2'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

  // The issuer's credit accounting guarantees a push never meets a full FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_ni && push_i) assert (!full);
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/command_fetch.sv
// command_fetch: issuing side of the 24-bit command interface.
// Reads program ROM at fetchPtr, prefetches into a 2-entry queue and presents
// one command per cycle with valid/ready. Redirects on jumpValid, stops on HALT.
// Ports:
//   clock   rising-edge clock
//   resetN  asynchronous active-low reset
//   bus     command_fetch_if.master: ROM read port, command handshake,
//           instructionPointer, jump request, halted
module command_fetch
  import command_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                CMD_W    = 24,
  parameter logic [ADDR_W-1:0] RESET_IP = '0
) (
  input  logic            clock,
  input  logic            resetN,
  command_fetch_if.master bus
);
  localparam int ENTRY_W = ADDR_W + CMD_W;

  fetch_state_e      state_q;
  logic              halted_q;
  logic [ADDR_W-1:0] fetchPtr_q;
  logic [ADDR_W-1:0] fetchPtr_d;
  logic              inFlight_q;
  logic [ADDR_W-1:0] inFlightAddr_q;

  logic [1:0]         fifoCount;
  logic [ENTRY_W-1:0] fifoRdata;
  logic [1:0]         occNow;
  logic [1:0]         occNext;
  logic               headValid;
  logic               pop;
  logic               retValid;
  logic               retHalt;
  logic               push;
  logic               issue;

  always_comb begin
    headValid = (fifoCount != 2'd0);
    pop       = headValid && bus.commandReady;
    // A jump squashes whatever ROM data comes back in the same cycle.
    retValid  = inFlight_q && !bus.jumpValid;
    retHalt   = retValid && is_halt(bus.memData);
    push      = retValid && !retHalt;
    // Credit: queued entries (after this cycle's pop) plus the read now returning.
    occNow    = fifoCount - 2'(pop) + 2'(inFlight_q);
    // No read is started while HALT is returning, so nothing is fetched past it.
    issue     = resetN && !halted_q && !bus.jumpValid && !retHalt && (occNow < 2'd2);
    occNext   = fifoCount - 2'(pop) + 2'(push) + 2'(issue);
    fetchPtr_d = fetchPtr_q;
    if (bus.jumpValid) begin
      fetchPtr_d = bus.jumpTarget;
    end else if (issue) begin
      fetchPtr_d = fetchPtr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q        <= ST_RUN;
      halted_q       <= 1'b0;
      fetchPtr_q     <= RESET_IP;
      inFlight_q     <= 1'b0;
      inFlightAddr_q <= '0;
    end else begin
      fetchPtr_q     <= fetchPtr_d;
      inFlight_q     <= issue;
      inFlightAddr_q <= fetchPtr_q;
      case (state_q)
        ST_RUN, ST_STALL: begin
          if (bus.jumpValid) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
          end else if (retHalt) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end else if (occNext == 2'd2) begin
            state_q  <= ST_STALL;
          end else begin
            state_q  <= ST_RUN;
          end
        end
        ST_HALT: begin
          // Only a redirect restarts fetching; the queue drains meanwhile.
          if (bus.jumpValid) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  cmd_fifo #(.WIDTH(ENTRY_W)) u_cmd_fifo (
    .clk_i   (clock),
    .rst_ni  (resetN),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (bus.jumpValid),
    .wdata_i ({inFlightAddr_q, bus.memData}),
    .rdata_o (fifoRdata),
    .count_o (fifoCount)
  );

  // Outputs are forced to zero while the queue is empty so reset clears them at once.
  assign bus.memRdEn            = issue;
  assign bus.memAddr            = issue ? fetchPtr_q : '0;
  assign bus.commandValid       = headValid;
  assign bus.commandOut         = headValid ? fifoRdata[CMD_W-1:0] : '0;
  assign bus.instructionPointer = headValid ? fifoRdata[ENTRY_W-1:CMD_W] : '0;
  assign bus.halted             = halted_q;
endmodule
